seq_pattern_tx: RTL

Bit-serial pattern transmitter. Loads a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, a programmable number of times with an optional idle gap between repetitions. It is the driving end of the serial sequence-detector path: `dout_bit` connects directly to a detector's `din_bit`, so benches and on-board self-test no longer need hand-timed stimulus.

---
 rtl/seq_pkg.sv | 14 +
 rtl/piso_shreg.sv | 33 +++
 rtl/seq_pattern_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial pattern transmitter and the
// sequence detector on the same serial path.
//   - FSM state encoding, so both ends decode identically in waveforms/debug
//   - default pattern width
package seq_pkg;

  localparam int SEQ_WIDTH = 8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] GAP_WAIT = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-in / serial-out shift register, MSB first.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the register
//   load  : capture din (takes priority over shift)
//   shift : shift left by one, zero-filling the LSB
//   din   : parallel load value
//   msb   : current most significant bit
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_p0 <= '0;
    end else if (load) begin
      sr_p0 <= din;
    end else if (shift) begin
      sr_p0 <= {sr_p0[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_p0[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
// Sends a latched WIDTH-bit pattern MSB-first, rep_cnt times, with GAP idle
// cycles between repetitions, then pulses done.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : request a transmission (only honoured in IDLE)
//   abort      : cancel a transmission, no done pulse
//   pattern    : bits to send, latched on accepted start
//   rep_cnt    : number of repetitions, latched on accepted start
//   dout_bit   : serial data, 0 whenever dout_valid is 0
//   dout_valid : dout_bit carries a pattern bit
//   busy       : transmission in progress, including the done cycle
//   done       : single-cycle completion pulse
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] rep_cnt,
  output logic             dout_bit,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [1:0]       state_p0, state_n;
  logic [BW-1:0]    bit_cnt_p0, bit_cnt_n;
  logic [REP_W-1:0] rep_left_p0, rep_left_n;
  logic [GW-1:0]    gap_cnt_p0, gap_cnt_n;
  logic [WIDTH-1:0] pat_copy_p0;
  logic             pat_copy_we;

  logic             sr_load, sr_shift, sr_msb;
  logic [WIDTH-1:0] sr_din;

  logic             bit_n, valid_n, busy_n, done_n;

  // The output bit is a flop of its own, so the shift register runs one bit
  // ahead: it is loaded with the pattern already shifted by one, while the
  // pattern MSB goes straight into dout_bit. Its msb is then always the bit
  // to present on the next cycle.
  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  always_comb begin
    state_n     = state_p0;
    bit_cnt_n   = bit_cnt_p0;
    rep_left_n  = rep_left_p0;
    gap_cnt_n   = gap_cnt_p0;
    pat_copy_we = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_din      = {pat_copy_p0[WIDTH-2:0], 1'b0};
    bit_n       = 1'b0;
    valid_n     = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    if (abort && state_p0 != IDLE) begin
      state_n = IDLE;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start && !abort) begin
            pat_copy_we = 1'b1;
            rep_left_n  = rep_cnt;
            bit_cnt_n   = '0;
            gap_cnt_n   = '0;
            sr_load     = 1'b1;
            sr_din      = {pattern[WIDTH-2:0], 1'b0};
            busy_n      = 1'b1;
            if (rep_cnt != '0) begin
              state_n = SHIFT;
              valid_n = 1'b1;
              bit_n   = pattern[WIDTH-1];
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end

        SHIFT: begin
          busy_n = 1'b1;
          if (bit_cnt_p0 == BIT_LAST) begin
            bit_cnt_n  = '0;
            rep_left_n = rep_left_p0 - 1'b1;
            if (rep_left_p0 == REP_ONE) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              sr_load = 1'b1;
              if (GAP > 0) begin
                state_n   = GAP_WAIT;
                gap_cnt_n = '0;
              end else begin
                valid_n = 1'b1;
                bit_n   = pat_copy_p0[WIDTH-1];
              end
            end
          end else begin
            bit_cnt_n = bit_cnt_p0 + 1'b1;
            sr_shift  = 1'b1;
            valid_n   = 1'b1;
            bit_n     = sr_msb;
          end
        end

        GAP_WAIT: begin
          busy_n = 1'b1;
          if (gap_cnt_p0 == GAP_LAST) begin
            state_n = SHIFT;
            valid_n = 1'b1;
            bit_n   = pat_copy_p0[WIDTH-1];
          end else begin
            gap_cnt_n = gap_cnt_p0 + 1'b1;
          end
        end

        DONE: begin
          state_n = IDLE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // ---- state / counter / output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      bit_cnt_p0  <= '0;
      rep_left_p0 <= '0;
      gap_cnt_p0  <= '0;
      pat_copy_p0 <= '0;
      dout_bit    <= 1'b0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_p0    <= state_n;
      bit_cnt_p0  <= bit_cnt_n;
      rep_left_p0 <= rep_left_n;
      gap_cnt_p0  <= gap_cnt_n;
      if (pat_copy_we) begin
        pat_copy_p0 <= pattern;
      end
      dout_bit    <= bit_n;
      dout_valid  <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule
